fxy_sweep_ctrl: RTL and testbench

- Sequencer that drives an external combinational function unit with every input vector in ascending order.
- Waits a programmable settle time per vector, captures the unit's outputs into a packed result register and compares them against a golden truth table.
- Reports pass/fail, mismatch count and first failing vector.
- Sits beside a two-input/two-output gate block (s1, s2 from x, y) as its self-check engine; sizes are parameterised.

---
 rtl/fxy_sweep_ctrl.sv | 157 +++++++++++++++
 tb/tb_fxy_sweep_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxy_sweep_ctrl.sv
// Exhaustive self-check sequencer for a small combinational unit: walks every input
// vector, waits a settle time, captures the outputs and grades them against a golden table.
module fxy_sweep_ctrl #(
  parameter int NIN    = 2,
  parameter int NOUT   = 2,
  parameter int SETTLE = 1,
  parameter logic [NOUT*(2**NIN)-1:0] EXPECT = 8'h5E
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [NIN-1:0]           vec_out,
  output logic                     drive_en,
  input  logic [NOUT-1:0]          res_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NIN:0]             err_cnt,
  output logic [NIN-1:0]           first_fail,
  output logic [NOUT*(2**NIN)-1:0] result
);

  localparam int NVEC = 2**NIN;
  localparam int RW   = NOUT*NVEC;
  localparam logic [NIN-1:0] LAST_IDX    = NIN'(NVEC-1);
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE-1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [NIN-1:0]  idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NIN-1:0]  vec_out_q, vec_out_d;
  logic            drive_en_q, drive_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [NIN:0]    err_cnt_q, err_cnt_d;
  logic [NIN-1:0]  first_fail_q, first_fail_d;
  logic [RW-1:0]   result_q, result_d;
  logic            mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      vec_out_q    <= '0;
      drive_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      vec_out_q    <= vec_out_d;
      drive_en_q   <= drive_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that every port comes straight off a flop.
  always_comb begin
    mismatch     = (res_in != EXPECT[idx_q*NOUT +: NOUT]);
    busy_d       = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    drive_en_d   = busy_d;
    vec_out_d    = busy_d ? idx_d : '0;
    done_d       = (state_d == S_DONE);
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    result_d     = result_q;

    if (state_q == S_IDLE && start) begin
      result_d     = '0;
      err_cnt_d    = '0;
      first_fail_d = '0;
      pass_d       = 1'b0;
    end

    if ((state_q == S_DRIVE || state_q == S_SAMPLE) && abort) begin
      pass_d = 1'b0;
    end

    if (state_q == S_SAMPLE && !abort) begin
      result_d[idx_q*NOUT +: NOUT] = res_in;
      if (mismatch) begin
        err_cnt_d = err_cnt_q + (NIN+1)'(1);
        if (err_cnt_q == '0) begin
          first_fail_d = idx_q;
        end
      end
    end

    // Grade on the updated count so the final sample is included.
    if (state_d == S_DONE) begin
      pass_d = (err_cnt_d == '0);
    end
  end

  assign vec_out    = vec_out_q;
  assign drive_en   = drive_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign first_fail = first_fail_q;
  assign result     = result_q;

endmodule

// File: tb/tb_fxy_sweep_ctrl.sv
// Scoreboard bench: each accepted start queues the expected sweep outcome, and a monitor
// per instance pops and grades it when done pulses.
module tb_fxy_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       rst_a, start_a, abort_a, fault_a;
  logic [1:0] vec_a, res_a, ff_a;
  logic       den_a, busy_a, done_a, pass_a;
  logic [2:0] err_a;
  logic [7:0] result_a;

  logic       rst_b, start_b, abort_b;
  logic [1:0] vec_b, res_b, ff_b;
  logic       den_b, busy_b, done_b, pass_b;
  logic [2:0] err_b;
  logic [7:0] result_b;

  function automatic logic [1:0] fxy(input logic [1:0] v, input logic s2_stuck0);
    logic s1, s2;
    s1 = ~v[1];
    s2 = s2_stuck0 ? 1'b0 : (v[1] | v[0]);
    return {s1, s2};
  endfunction

  assign res_a = fxy(vec_a, fault_a);
  assign res_b = fxy(vec_b, 1'b0);

  fxy_sweep_ctrl dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .abort(abort_a),
    .vec_out(vec_a), .drive_en(den_a), .res_in(res_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_cnt(err_a), .first_fail(ff_a),
    .result(result_a)
  );

  fxy_sweep_ctrl #(.SETTLE(3)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .abort(abort_b),
    .vec_out(vec_b), .drive_en(den_b), .res_in(res_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_cnt(err_b), .first_fail(ff_b),
    .result(result_b)
  );

  typedef struct packed {
    logic [7:0]  res;
    logic [2:0]  err;
    logic [1:0]  ff;
    logic        pass;
    logic [31:0] cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        ea = q_a.pop_front();
        chk("a_result", result_a, ea.res);
        chk("a_err_cnt", err_a, ea.err);
        chk("a_first_fail", ff_a, ea.ff);
        chk("a_pass", pass_a, ea.pass);
        chk("a_done_cycle", cyc, ea.cyc);
        chk("a_busy_in_done", {busy_a, den_a}, 2'b00);
        $display("sweep A done: cyc=%0d result=%0h err=%0d ff=%0d pass=%0b",
                 cyc, result_a, err_a, ff_a, pass_a);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        eb = q_b.pop_front();
        chk("b_result", result_b, eb.res);
        chk("b_err_cnt", err_b, eb.err);
        chk("b_first_fail", ff_b, eb.ff);
        chk("b_pass", pass_b, eb.pass);
        chk("b_done_cycle", cyc, eb.cyc);
        $display("sweep B done: cyc=%0d result=%0h err=%0d ff=%0d pass=%0b",
                 cyc, result_b, err_b, ff_b, pass_b);
      end
    end
  end

  // Called #1 after an edge; start is sampled at the following edge.
  task automatic go_a(input logic [7:0] r, input logic [2:0] e, input logic [1:0] f,
                      input logic p, input int lat);
    exp_t x;
    x.res = r; x.err = e; x.ff = f; x.pass = p; x.cyc = 32'(cyc + 1 + lat);
    q_a.push_back(x);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic [7:0] r, input logic [2:0] e, input logic [1:0] f,
                      input logic p, input int lat);
    exp_t x;
    x.res = r; x.err = e; x.ff = f; x.pass = p; x.cyc = 32'(cyc + 1 + lat);
    q_b.push_back(x);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_a(input int maxc);
    int n = 0;
    while (q_a.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic wait_b(input int maxc);
    int n = 0;
    while (q_b.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic chk_all_zero_a(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_drive_en"}, den_a, 0);
    chk({tag, "_vec_out"}, vec_a, 0);
    chk({tag, "_err_cnt"}, err_a, 0);
    chk({tag, "_first_fail"}, ff_a, 0);
    chk({tag, "_result"}, result_a, 0);
  endtask

  initial begin
    int n0;
    rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; fault_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero_a("reset");
    chk("reset_b_busy", busy_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    // Clean sweep, 2 cycles per vector
    go_a(8'h5E, 3'd0, 2'd0, 1'b1, 8);
    for (int t = 0; t < 8; t++) begin
      chk("a_vec_step", vec_a, 32'(t / 2));
      chk("a_drive_en", {den_a, busy_a}, 2'b11);
      @(posedge clk); #1;
    end
    wait_a(20);
    chk("a_pass_holds", pass_a, 1);

    // s2 stuck at 0: vectors 1..3 mismatch
    fault_a = 1'b1;
    go_a(8'h0A, 3'd3, 2'd1, 1'b0, 8);
    wait_a(20);
    fault_a = 1'b0;

    // SETTLE=3 instance: 4 cycles per vector
    go_b(8'h5E, 3'd0, 2'd0, 1'b1, 16);
    for (int t = 0; t < 16; t++) begin
      chk("b_vec_step", vec_b, 32'(t / 4));
      @(posedge clk); #1;
    end
    wait_b(30);

    // Abort while idx=2 is in DRIVE
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_vec", vec_a, 2);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_drive_en", den_a, 0);
    chk("abort_pass", pass_a, 0);
    chk("abort_result", result_a, 8'h0E);
    chk("abort_err_cnt", err_a, 0);
    chk("abort_first_fail", ff_a, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_idle_result", result_a, 8'h0E);

    // start and abort together in IDLE: start wins
    abort_a = 1'b1;
    go_a(8'h5E, 3'd0, 2'd0, 1'b1, 8);
    abort_a = 1'b0;
    wait_a(20);

    // Asynchronous reset in the middle of SAMPLE for idx=1
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_result", result_a, 8'h02);
    chk("pre_reset_vec", vec_a, 1);
    #2;
    rst_a = 1'b1;
    #1;
    chk_all_zero_a("midreset");
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(posedge clk); #1;
    go_a(8'h5E, 3'd0, 2'd0, 1'b1, 8);
    wait_a(20);

    // start held high: back-to-back sweeps 10 cycles apart, no extra sweeps
    n0 = cyc;
    begin
      exp_t x;
      x.res = 8'h5E; x.err = 3'd0; x.ff = 2'd0; x.pass = 1'b1;
      x.cyc = 32'(n0 + 9);
      q_a.push_back(x);
      x.cyc = 32'(n0 + 19);
      q_a.push_back(x);
    end
    start_a = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    start_a = 1'b0;
    wait_a(30);
    repeat (12) @(posedge clk);
    #1;
    chk("held_start_idle", busy_a, 0);

    wait_a(30);
    wait_b(30);
    while (q_a.size() != 0) begin
      void'(q_a.pop_front());
      chk("a_missing_done", 32'd0, 32'd1);
    end
    while (q_b.size() != 0) begin
      void'(q_b.pop_front());
      chk("b_missing_done", 32'd0, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
